// File: rtl/serial_pattern_tx.sv
// Serialises an MSB-first slice of a latched pattern, repeated a configurable number of times
// with optional idle gaps between repetitions. All outputs are registered.
module serial_pattern_tx #(
  parameter int DATA_W = 8,
  parameter int REP_W  = 4,
  localparam int NB_W  = $clog2(DATA_W) + 1,
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] pattern,
  input  logic [NB_W-1:0]   nbits,
  input  logic [REP_W-1:0]  reps,
  input  logic [3:0]        gap,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done,
  output logic [REP_W-1:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [NB_W-1:0] DATA_W_N = NB_W'(DATA_W);

  state_t             state;
  logic [DATA_W-1:0]  pat_r;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   bit_idx;
  logic [REP_W-1:0]   reps_r;
  logic [3:0]         gap_r;
  logic [3:0]         gap_left;
  logic [REP_W-1:0]   next_cnt;
  logic               more_reps;

  // An out-of-range bit count (0 or wider than the pattern) sends the full pattern.
  function automatic logic [IDX_W-1:0] last_idx(input logic [NB_W-1:0] n);
    if (n == '0 || n > DATA_W_N) return IDX_W'(DATA_W - 1);
    else                         return IDX_W'(n - 1'b1);
  endfunction

  assign next_cnt  = frame_cnt + 1'b1;
  assign more_reps = (reps_r == '0) || (next_cnt != reps_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      pat_r     <= '0;
      first_idx <= '0;
      bit_idx   <= '0;
      reps_r    <= '0;
      gap_r     <= '0;
      gap_left  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            pat_r     <= pattern;
            first_idx <= last_idx(nbits);
            bit_idx   <= last_idx(nbits);
            reps_r    <= reps;
            gap_r     <= gap;
            frame_cnt <= '0;
            ser_out   <= pattern[last_idx(nbits)];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // The bit on the wire this cycle counts as sent even when stop aborts.
          if (stop) begin
            if (bit_idx == '0) frame_cnt <= next_cnt;
            state     <= DONE;
            done      <= 1'b1;
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
          end else if (bit_idx == '0) begin
            frame_cnt <= next_cnt;
            if (!more_reps) begin
              state     <= DONE;
              done      <= 1'b1;
              ser_valid <= 1'b0;
              ser_out   <= 1'b0;
            end else if (gap_r == 4'd0) begin
              bit_idx <= first_idx;
              ser_out <= pat_r[first_idx];
            end else begin
              state     <= GAP;
              gap_left  <= gap_r - 4'd1;
              ser_valid <= 1'b0;
              ser_out   <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx - 1'b1;
            ser_out <= pat_r[bit_idx - 1'b1];
          end
        end
        GAP: begin
          if (stop) begin
            state     <= DONE;
            done      <= 1'b1;
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
          end else if (gap_left == 4'd0) begin
            state     <= SEND;
            bit_idx   <= first_idx;
            ser_out   <= pat_r[first_idx];
            ser_valid <= 1'b1;
          end else begin
            gap_left <= gap_left - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          ser_valid <= 1'b0;
          ser_out   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed scenarios plus randomized transfers,
// compared cycle by cycle against a stream-level reference model.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] pattern;
  logic [3:0] nbits;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;
  logic [3:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       valid;
    logic       sbit;
    logic       dn;
    logic       bsy;
    logic [3:0] cnt;
  } obs_t;

  obs_t exp_q[$];

  serial_pattern_tx #(.DATA_W(8), .REP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pattern(pattern), .nbits(nbits), .reps(reps), .gap(gap),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy),
    .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Expected per-cycle outputs, starting with the cycle after start is sampled.
  // stop_at is the stream index during which stop is held high (-1 for none).
  task automatic build_expect(input logic [7:0] p, input logic [3:0] nb, input logic [3:0] rp,
                              input logic [3:0] gp, input int stop_at);
    int n;
    logic [3:0] cnt;
    bit fin;
    exp_q.delete();
    n   = (nb == 0 || nb > 8) ? 8 : int'(nb);
    cnt = 4'd0;
    fin = 1'b0;
    while (!fin && exp_q.size() < 2000) begin
      for (int b = n - 1; b >= 0 && !fin; b--) begin
        exp_q.push_back({1'b1, p[b], 1'b0, 1'b1, cnt});
        if (exp_q.size() - 1 == stop_at) begin
          if (b == 0) cnt++;
          fin = 1'b1;
        end
      end
      if (fin) break;
      cnt++;
      if (rp != 0 && cnt == rp) break;
      for (int g = 0; g < int'(gp) && !fin; g++) begin
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, cnt});
        if (exp_q.size() - 1 == stop_at) fin = 1'b1;
      end
    end
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, cnt});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, cnt});
  endtask

  // Called right after a falling edge; returns right after the falling edge of the idle cycle.
  task automatic run_transfer(input string name, input logic [7:0] p, input logic [3:0] nb,
                              input logic [3:0] rp, input logic [3:0] gp, input int stop_at,
                              input bit noise, input bit stop_with_start);
    obs_t act;
    build_expect(p, nb, rp, gp, stop_at);
    pattern = p; nbits = nb; reps = rp; gap = gp;
    start = 1'b1;
    stop  = stop_with_start;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      act = {ser_valid, ser_out, done, busy, frame_cnt};
      checks++;
      if (act !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got valid=%b out=%b done=%b busy=%b cnt=%0d, expected valid=%b out=%b done=%b busy=%b cnt=%0d",
                 name, i, act.valid, act.sbit, act.dn, act.bsy, act.cnt,
                 exp_q[i].valid, exp_q[i].sbit, exp_q[i].dn, exp_q[i].bsy, exp_q[i].cnt);
      end
      stop = (i == stop_at);
      if (noise && i < exp_q.size() - 1) begin
        start   = 1'($urandom);
        pattern = 8'($urandom);
        nbits   = 4'($urandom);
        reps    = 4'($urandom);
        gap     = 4'($urandom);
        if (i == exp_q.size() - 2) stop = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (i == exp_q.size() - 1) stop = 1'b0;
      if (i < exp_q.size() - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    pattern = 8'hFF; nbits = 4'd4; reps = 4'd1; gap = 4'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ser_valid, ser_out, done, busy, frame_cnt} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b, expected %b", {ser_valid, ser_out, done, busy, frame_cnt}, 8'h00);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_single();
    run_transfer("single_0A", 8'h0A, 4'd4, 4'd1, 4'd0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reps_gap();
    run_transfer("reps3_gap2", 8'h0A, 4'd4, 4'd3, 4'd2, -1, 1'b0, 1'b0);
  endtask

  task automatic test_continuous_stop();
    run_transfer("continuous_stop", 8'h0A, 4'd4, 4'd0, 4'd0, 18, 1'b0, 1'b0);
  endtask

  task automatic test_nbits_zero();
    run_transfer("nbits0_A5", 8'hA5, 4'd0, 4'd1, 4'd0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_rst_mid_send();
    pattern = 8'h0A; nbits = 4'd4; reps = 4'd2; gap = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({ser_valid, ser_out, busy} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL rst_pre_send: got %b, expected %b", {ser_valid, ser_out, busy}, 3'b101);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ser_valid, ser_out, done, busy, frame_cnt} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_mid_send: got %b, expected %b", {ser_valid, ser_out, done, busy, frame_cnt}, 8'h00);
    end
    rst = 1'b0;
    run_transfer("after_rst", 8'h0A, 4'd4, 4'd1, 4'd0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_transfer("start_busy", 8'h0A, 4'd4, 4'd2, 4'd1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_start_stop_together();
    run_transfer("start_stop_idle", 8'hC3, 4'd6, 4'd2, 4'd0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    run_transfer("cnt_wrap", 8'h02, 4'd2, 4'd0, 4'd0, 36, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic [3:0] nb, rp, gp;
    int sa;
    for (int k = 0; k < 8; k++) begin
      p  = 8'($urandom);
      nb = 4'($urandom_range(0, 15));
      rp = 4'($urandom_range(0, 4));
      gp = 4'($urandom_range(0, 3));
      if (rp == 0)             sa = int'($urandom_range(0, 30));
      else if ($urandom % 2)   sa = int'($urandom_range(0, 20));
      else                     sa = -1;
      run_transfer("random", p, nb, rp, gp, sa, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    pattern = 8'h00; nbits = 4'd0; reps = 4'd0; gap = 4'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_reps_gap();
    test_continuous_stop();
    test_nbits_zero();
    test_rst_mid_send();
    test_start_while_busy();
    test_start_stop_together();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pattern width in bits.
REQ-002 SHALL have parameter REP_W, default 4: width of the repetition count and frame_cnt.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: request a transfer; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1: abort a transfer; sampled only in SEND or GAP.
REQ-007 SHALL have port pattern  input  DATA_W: bits to serialise.
REQ-008 SHALL have port nbits  input  clog2(DATA_W)+1: bits per repetition.
REQ-009 SHALL have port reps  input  REP_W: repetition count; 0 means continuous.
REQ-010 SHALL have port gap  input  4: idle cycles inserted between repetitions.
REQ-011 SHALL have port ser_out  output  1: serial data bit.
REQ-012 SHALL have port ser_valid  output  1: ser_out carries a pattern bit this cycle.
REQ-013 SHALL have port busy  output  1: high whenever the state is not IDLE.
REQ-014 SHALL have port done  output  1: one-cycle pulse at the end of a transfer.
REQ-015 SHALL have port frame_cnt  output  REP_W: repetitions completed in the current or last transfer.

Function
REQ-016 SHALL implement an FSM with states IDLE, SEND, GAP and DONE; all outputs SHALL be registered.
REQ-017 In IDLE with start=1, SHALL latch pattern, nbits, reps and gap, clear frame_cnt, and enter SEND on the next edge.
REQ-018 SHALL treat a latched nbits of 0 or greater than DATA_W as DATA_W.
REQ-019 SHALL send pattern[nbits-1] first, down to pattern[0]; one bit per cycle in SEND with ser_valid=1.
REQ-020 SHALL output the first bit in the cycle immediately after start is sampled (latency 1).
REQ-021 After the last bit of a repetition, SHALL increment frame_cnt, wrapping modulo 2^REP_W.
REQ-022 If more repetitions remain (or reps=0) and gap=0, SHALL restart SEND back-to-back with no bubble.
REQ-023 If more repetitions remain (or reps=0) and gap>0, SHALL spend exactly gap cycles in GAP (ser_valid=0, ser_out=0), then return to SEND.
REQ-024 After the final repetition (frame_cnt reaches a non-zero reps), SHALL enter DONE for one cycle with done=1, then return to IDLE.
REQ-025 stop sampled high in SEND or GAP SHALL force DONE on the next edge; a bit presented in the cycle stop is sampled counts as sent, but an unfinished repetition SHALL NOT increment frame_cnt.
REQ-026 SHALL ignore start in every state except IDLE, and SHALL ignore stop in IDLE and DONE.
REQ-027 If start and stop are both high in IDLE, SHALL accept start.
REQ-028 SHALL drive ser_out=0 whenever ser_valid=0.
REQ-029 SHALL hold frame_cnt after DONE until the next accepted start.
REQ-030 SHALL ignore changes on pattern, nbits, reps and gap while busy=1.

Reset
REQ-031 On rst=1 at a rising edge, SHALL set the state to IDLE and clear ser_out, ser_valid, busy, done and frame_cnt to 0.
REQ-032 rst SHALL override start and stop, and SHALL discard latched configuration mid-transfer without producing a done pulse.
REQ-033 SHALL accept start on the first edge after rst is deasserted.

Verification
REQ-034 Bench SHALL cover: pattern=8'h0A, nbits=4, reps=1, gap=0, start at cycle T -> ser_valid high T+1..T+4 with ser_out 1,0,1,0; done high at T+5; busy high T+1..T+5; frame_cnt=1.
REQ-035 Bench SHALL cover: pattern=8'h0A, nbits=4, reps=3, gap=2 -> 1010, two invalid cycles, 1010, two invalid cycles, 1010, then done; frame_cnt=3.
REQ-036 Bench SHALL cover: reps=0, gap=0, pattern 1010 -> continuous 1010 stream with no bubbles; stop asserted on the 3rd bit of the 5th repetition -> ser_valid=0 and done=1 on the next cycle; frame_cnt=4.
REQ-037 Bench SHALL cover: pattern=8'hA5, nbits=0 -> 8 bits 1,0,1,0,0,1,0,1 sent.
REQ-038 Bench SHALL cover: rst asserted during SEND -> next cycle all outputs 0 and no done; a following start sends the pattern correctly.
REQ-039 Bench SHALL cover: start pulsed while busy -> ignored and the transfer is unchanged; start and stop together in IDLE -> transfer starts.
